// File: rtl/plic_ng_pkg.sv
// Shared constants, register-select type and address decoder for the PLIC.
package plic_ng_pkg;

  localparam int PLIC_MAX_NSRC   = 31;
  localparam int PLIC_MAX_PRIO_W = 5;
  localparam int PLIC_ID_W       = 5;

  // Byte offsets inside the 28-bit decoded window.
  localparam logic [27:0] PLIC_PRIO_BASE = 28'h000_0000;
  localparam logic [27:0] PLIC_IP_OFF    = 28'h000_1000;
  localparam logic [27:0] PLIC_IE_OFF    = 28'h000_2000;
  localparam logic [27:0] PLIC_EDGE_OFF  = 28'h000_3000;
  localparam logic [27:0] PLIC_THR_OFF   = 28'h020_0000;
  localparam logic [27:0] PLIC_CPC_OFF   = 28'h020_0004;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PRIO,
    SEL_IP,
    SEL_IE,
    SEL_EDGE,
    SEL_THR,
    SEL_CPC
  } reg_sel_e;

  // Maps an offset to a register; PRIO[0] and PRIO[i>nsrc] fall to SEL_NONE.
  function automatic reg_sel_e plic_decode(input logic [27:0] addr, input logic [5:0] nsrc);
    logic [4:0] idx;
    idx = addr[6:2];
    plic_decode = SEL_NONE;
    case (addr)
      PLIC_IP_OFF:   plic_decode = SEL_IP;
      PLIC_IE_OFF:   plic_decode = SEL_IE;
      PLIC_EDGE_OFF: plic_decode = SEL_EDGE;
      PLIC_THR_OFF:  plic_decode = SEL_THR;
      PLIC_CPC_OFF:  plic_decode = SEL_CPC;
      default: begin
        if ((addr[27:7] == PLIC_PRIO_BASE[27:7]) && (addr[1:0] == 2'd0) &&
            (idx != 5'd0) && ({1'b0, idx} <= nsrc))
          plic_decode = SEL_PRIO;
      end
    endcase
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: pending bit, in-service bit and edge history.
module plic_gateway (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  input  logic edge_mode,
  input  logic edge_chg,
  input  logic claim,
  input  logic complete,
  output logic ip,
  output logic in_service
);

  logic irq_q;
  logic set_ip;

  // Edge sources latch a rising edge even while in service; level sources
  // only become pending when not already being serviced.
  assign set_ip = edge_mode ? (irq & ~irq_q) : (irq & ~in_service);

  // Claim and a mode change both beat a same-cycle assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip         <= 1'b0;
      in_service <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (claim || edge_chg) ip <= 1'b0;
      else if (set_ip)       ip <= 1'b1;
      if (claim)             in_service <= 1'b1;
      else if (complete)     in_service <= 1'b0;
      irq_q <= edge_chg ? 1'b0 : irq;
    end
  end

endmodule

// File: rtl/plic_ng.sv
// Single-context PLIC with an ICB register port and a registered trap output.
// Handshake: a command is accepted when cmd_valid & cmd_ready; the response is
// offered from the next cycle and held stable until rsp_valid & rsp_ready.
module plic_ng
  import plic_ng_pkg::*;
#(
  parameter int NSRC   = 31,
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [31:0]       icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [31:0]       icb_cmd_wdata,
  input  logic [3:0]        icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [31:0]       icb_rsp_rdata,
  output logic              icb_rsp_err,
  input  logic [NSRC:0]     irq_i,
  output logic              core_ex_trap_valid_o,
  output logic [4:0]        core_ex_trap_id_o,
  input  logic              core_ex_trap_ready_i
);

  logic [PRIO_W-1:0] prio [1:NSRC];
  logic [PRIO_W-1:0] thr;
  logic [NSRC:1]     ie, edge_mode, ip, in_service;
  logic [NSRC:1]     claim_vec, complete_vec, edge_chg;

  logic [27:0]       cmd_off;
  logic [4:0]        cmd_idx;
  reg_sel_e          sel;
  logic              cmd_hs, rd_hs, wr_hs;
  logic [31:0]       rd_val;
  logic              rd_err;

  logic [4:0]        best_id;
  logic [PRIO_W-1:0] best_prio;
  logic              core_claim, bus_claim, cpl_hit;
  logic [4:0]        claim_id;

  logic              unused_ok;
  assign unused_ok = ^{icb_cmd_wmask, icb_cmd_addr[31:28], irq_i[0]};

  assign cmd_off       = icb_cmd_addr[27:0];
  assign cmd_idx       = cmd_off[6:2];
  assign sel           = plic_decode(cmd_off, 6'(NSRC));
  assign icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready;
  assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;
  assign rd_hs         = cmd_hs & icb_cmd_read;
  assign wr_hs         = cmd_hs & ~icb_cmd_read;

  // A core claim uses the registered id and takes precedence over a bus claim,
  // so a coincident CLAIM read reports the core's id and only one claim occurs.
  assign core_claim = core_ex_trap_ready_i & (core_ex_trap_id_o != 5'd0);
  assign bus_claim  = rd_hs & (sel == SEL_CPC);
  assign claim_id   = core_claim ? core_ex_trap_id_o : (bus_claim ? best_id : 5'd0);
  assign cpl_hit    = wr_hs & (sel == SEL_CPC) & (icb_cmd_wdata != 32'd0) &
                      (icb_cmd_wdata <= 32'(NSRC));

  for (genvar g = 1; g <= NSRC; g++) begin : g_src
    assign claim_vec[g]    = (claim_id == 5'(g));
    assign complete_vec[g] = cpl_hit & (icb_cmd_wdata[4:0] == 5'(g));
    assign edge_chg[g]     = wr_hs & (sel == SEL_EDGE) & (icb_cmd_wdata[g] != edge_mode[g]);

    plic_gateway u_gw (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq        (irq_i[g]),
      .edge_mode  (edge_mode[g]),
      .edge_chg   (edge_chg[g]),
      .claim      (claim_vec[g]),
      .complete   (complete_vec[g]),
      .ip         (ip[g]),
      .in_service (in_service[g])
    );
  end

  // Linear compare chain: strict '>' keeps the lowest id on a priority tie,
  // and a zero priority can never beat the initial best_prio of 0.
  always_comb begin
    best_id   = 5'd0;
    best_prio = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (ip[i] && ie[i] && (prio[i] > best_prio)) begin
        best_id   = 5'(i);
        best_prio = prio[i];
      end
    end
  end

  // Read mux; unmapped offsets flag an error and return zero.
  always_comb begin
    rd_val = 32'd0;
    rd_err = 1'b0;
    case (sel)
      SEL_PRIO: rd_val = 32'(prio[cmd_idx]);
      SEL_IP:   rd_val = 32'({ip, 1'b0});
      SEL_IE:   rd_val = 32'({ie, 1'b0});
      SEL_EDGE: rd_val = 32'({edge_mode, 1'b0});
      SEL_THR:  rd_val = 32'(thr);
      SEL_CPC:  rd_val = 32'(claim_id);
      default:  rd_err = 1'b1;
    endcase
  end

  // Configuration registers, written at the command handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NSRC; i++) prio[i] <= '0;
      ie        <= '0;
      edge_mode <= '0;
      thr       <= '0;
    end else if (wr_hs) begin
      case (sel)
        SEL_PRIO: prio[cmd_idx] <= icb_cmd_wdata[PRIO_W-1:0];
        SEL_IE:   ie            <= icb_cmd_wdata[NSRC:1];
        SEL_EDGE: edge_mode     <= icb_cmd_wdata[NSRC:1];
        SEL_THR:  thr           <= icb_cmd_wdata[PRIO_W-1:0];
        default:  ;
      endcase
    end
  end

  // Response register: loads on handshake, holds until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icb_rsp_valid <= 1'b0;
      icb_rsp_rdata <= 32'd0;
      icb_rsp_err   <= 1'b0;
    end else if (cmd_hs) begin
      icb_rsp_valid <= 1'b1;
      icb_rsp_rdata <= icb_cmd_read ? rd_val : 32'd0;
      icb_rsp_err   <= rd_err;
    end else if (icb_rsp_ready) begin
      icb_rsp_valid <= 1'b0;
    end
  end

  // Registered trap request: the arbitration winner and its threshold test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ex_trap_valid_o <= 1'b0;
      core_ex_trap_id_o    <= 5'd0;
    end else begin
      core_ex_trap_valid_o <= (best_prio > thr);
      core_ex_trap_id_o    <= best_id;
    end
  end

endmodule

// File: tb/tb_plic_ng.sv
// Self-checking bench for plic_ng: directed scenarios plus a cycle model.
module tb_plic_ng;

  localparam int NSRC   = 31;
  localparam int PRIO_W = 3;
  localparam int A_PRIO = 'h0;
  localparam int A_IP   = 'h1000;
  localparam int A_IE   = 'h2000;
  localparam int A_EDGE = 'h3000;
  localparam int A_THR  = 'h200000;
  localparam int A_CPC  = 'h200004;
  localparam logic [31:0] SRC_MASK = 32'((64'd1 << (NSRC + 1)) - 64'd2);
  localparam int PMAX   = (1 << PRIO_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              icb_cmd_valid = 1'b0;
  logic              icb_cmd_ready;
  logic [31:0]       icb_cmd_addr = '0;
  logic              icb_cmd_read = 1'b0;
  logic [31:0]       icb_cmd_wdata = '0;
  logic [3:0]        icb_cmd_wmask = 4'hf;
  logic              icb_rsp_valid;
  logic              icb_rsp_ready = 1'b1;
  logic [31:0]       icb_rsp_rdata;
  logic              icb_rsp_err;
  logic [NSRC:0]     irq_i = '0;
  logic              core_ex_trap_valid_o;
  logic [4:0]        core_ex_trap_id_o;
  logic              core_ex_trap_ready_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  plic_ng #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .icb_cmd_valid        (icb_cmd_valid),
    .icb_cmd_ready        (icb_cmd_ready),
    .icb_cmd_addr         (icb_cmd_addr),
    .icb_cmd_read         (icb_cmd_read),
    .icb_cmd_wdata        (icb_cmd_wdata),
    .icb_cmd_wmask        (icb_cmd_wmask),
    .icb_rsp_valid        (icb_rsp_valid),
    .icb_rsp_ready        (icb_rsp_ready),
    .icb_rsp_rdata        (icb_rsp_rdata),
    .icb_rsp_err          (icb_rsp_err),
    .irq_i                (irq_i),
    .core_ex_trap_valid_o (core_ex_trap_valid_o),
    .core_ex_trap_id_o    (core_ex_trap_id_o),
    .core_ex_trap_ready_i (core_ex_trap_ready_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_prio [32];
  logic [31:0] m_ie, m_edge, m_ip, m_is, m_hist, m_rsp_rdata;
  int          m_thr, m_trap_id;
  logic        m_rsp_valid, m_rsp_err, m_trap_valid;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_prio[i] = 0;
    m_ie = '0; m_edge = '0; m_ip = '0; m_is = '0; m_hist = '0;
    m_thr = 0; m_trap_id = 0; m_trap_valid = 1'b0;
    m_rsp_valid = 1'b0; m_rsp_err = 1'b0; m_rsp_rdata = '0;
  endtask

  // Winner = the lowest id among enabled pending sources at the highest priority level.
  task automatic model_best(output int id, output int pr);
    id = 0;
    pr = 0;
    for (int p = PMAX; p >= 1 && id == 0; p--)
      for (int i = 1; i <= NSRC && id == 0; i++)
        if (m_ip[i] && m_ie[i] && m_prio[i] == p) begin
          id = i;
          pr = p;
        end
  endtask

  task automatic model_step();
    int a, bid, bpr, cid, cpl;
    logic hs, rd, err, core_cl, bus_cl;
    logic [31:0] rv, chg, nip, nis, nhist;
    a  = int'(icb_cmd_addr & 32'h0FFF_FFFF);
    hs = icb_cmd_valid && (!m_rsp_valid || icb_rsp_ready);
    rd = icb_cmd_read;
    model_best(bid, bpr);
    core_cl = core_ex_trap_ready_i && (m_trap_id != 0);
    bus_cl  = hs && rd && (a == A_CPC);
    cid     = core_cl ? m_trap_id : (bus_cl ? bid : 0);
    cpl     = 0;
    if (hs && !rd && a == A_CPC && icb_cmd_wdata >= 1 && icb_cmd_wdata <= NSRC)
      cpl = int'(icb_cmd_wdata);
    chg = (hs && !rd && a == A_EDGE) ? ((icb_cmd_wdata ^ m_edge) & SRC_MASK) : '0;
    err = 1'b0;
    rv  = '0;
    if (a == A_IP)        rv = m_ip;
    else if (a == A_IE)   rv = m_ie;
    else if (a == A_EDGE) rv = m_edge;
    else if (a == A_THR)  rv = 32'(m_thr);
    else if (a == A_CPC)  rv = 32'(cid);
    else if (a % 4 == 0 && a / 4 >= 1 && a / 4 <= NSRC) rv = 32'(m_prio[a / 4]);
    else err = 1'b1;
    nip = m_ip; nis = m_is; nhist = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (m_edge[i] ? (irq_i[i] && !m_hist[i]) : (irq_i[i] && !m_is[i])) nip[i] = 1'b1;
      if (cid == i || chg[i]) nip[i] = 1'b0;
      if (cid == i) nis[i] = 1'b1;
      else if (cpl == i) nis[i] = 1'b0;
      nhist[i] = chg[i] ? 1'b0 : irq_i[i];
    end
    m_trap_id    = bid;
    m_trap_valid = (bpr > m_thr);
    if (hs && !rd && !err) begin
      if (a == A_IE)        m_ie   = icb_cmd_wdata & SRC_MASK;
      else if (a == A_EDGE) m_edge = icb_cmd_wdata & SRC_MASK;
      else if (a == A_THR)  m_thr  = int'(icb_cmd_wdata) & PMAX;
      else if (a != A_IP && a != A_CPC) m_prio[a / 4] = int'(icb_cmd_wdata) & PMAX;
    end
    m_ip = nip; m_is = nis; m_hist = nhist;
    if (hs) begin
      m_rsp_valid = 1'b1;
      m_rsp_rdata = rd ? rv : 32'd0;
      m_rsp_err   = err;
    end else if (icb_rsp_ready) begin
      m_rsp_valid = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        check("cyc_cmd_ready", 32'(icb_cmd_ready), 32'(!m_rsp_valid || icb_rsp_ready));
        check("cyc_rsp_valid", 32'(icb_rsp_valid), 32'(m_rsp_valid));
        check("cyc_trap_valid", 32'(core_ex_trap_valid_o), 32'(m_trap_valid));
        check("cyc_trap_id", 32'(core_ex_trap_id_o), 32'(m_trap_id));
        if (m_rsp_valid) begin
          check("cyc_rsp_rdata", icb_rsp_rdata, m_rsp_rdata);
          check("cyc_rsp_err", 32'(icb_rsp_err), 32'(m_rsp_err));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic rd, input int a, input logic [31:0] d,
                     output logic [31:0] rdata, output logic err);
    int t;
    @(negedge clk);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = 32'(a);
    icb_cmd_wdata = d;
    icb_rsp_ready = 1'b1;
    t = 0;
    while (!icb_cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    icb_cmd_valid = 1'b0;
    t = 0;
    while (!icb_rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!icb_rsp_valid) check("bus_rsp_timeout", 32'(icb_rsp_valid), 32'd1);
    rdata = icb_rsp_rdata;
    err   = icb_rsp_err;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic exp_err);
    logic [31:0] r;
    logic e;
    bus(1'b0, a, d, r, e);
    check("wr_err", 32'(e), 32'(exp_err));
  endtask

  task automatic rd_chk(input string name, input int a, input logic [31:0] exp_d, input logic exp_err);
    logic [31:0] r;
    logic e;
    bus(1'b1, a, 32'd0, r, e);
    check(name, r, exp_d);
    check({name, "_err"}, 32'(e), 32'(exp_err));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
    check("rst_trap_valid", 32'(core_ex_trap_valid_o), 32'd0);
    check("rst_trap_id", 32'(core_ex_trap_id_o), 32'd0);
    check("rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(icb_cmd_ready), 32'd1);
    check("rst_rsp_rdata", icb_rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(icb_rsp_err), 32'd0);
    rd_chk("rst_ie", A_IE, 32'd0, 1'b0);

    // Level source 3: claim holds IP low until complete.
    wr(A_PRIO + 4 * 3, 32'd2, 1'b0);
    wr(A_IE, 32'h8, 1'b0);
    wr(A_THR, 32'd1, 1'b0);
    rd_chk("prio3_rb", A_PRIO + 4 * 3, 32'd2, 1'b0);
    irq_i[3] = 1'b1;
    cycles(2);
    check("l3_valid", 32'(core_ex_trap_valid_o), 32'd1);
    check("l3_id", 32'(core_ex_trap_id_o), 32'd3);
    core_ex_trap_ready_i = 1'b1;
    cycles(1);
    core_ex_trap_ready_i = 1'b0;
    cycles(1);
    check("l3_valid_drop", 32'(core_ex_trap_valid_o), 32'd0);
    rd_chk("l3_ip_in_service", A_IP, 32'd0, 1'b0);
    wr(A_CPC, 32'd3, 1'b0);
    rd_chk("l3_ip_reset", A_IP, 32'h8, 1'b0);
    irq_i[3] = 1'b0;
    rd_chk("l3_bus_claim", A_CPC, 32'd3, 1'b0);
    wr(A_CPC, 32'd3, 1'b0);

    // Priority tie between 5 and 9.
    wr(A_PRIO + 4 * 5, 32'd4, 1'b0);
    wr(A_PRIO + 4 * 9, 32'd4, 1'b0);
    wr(A_IE, 32'h220, 1'b0);
    wr(A_THR, 32'd0, 1'b0);
    irq_i[5] = 1'b1;
    irq_i[9] = 1'b1;
    cycles(2);
    check("tie_id5", 32'(core_ex_trap_id_o), 32'd5);
    core_ex_trap_ready_i = 1'b1;
    cycles(1);
    core_ex_trap_ready_i = 1'b0;
    cycles(1);
    check("tie_id9", 32'(core_ex_trap_id_o), 32'd9);
    irq_i[5] = 1'b0;
    irq_i[9] = 1'b0;
    rd_chk("tie_claim9", A_CPC, 32'd9, 1'b0);
    wr(A_CPC, 32'd9, 1'b0);
    wr(A_CPC, 32'd5, 1'b0);
    wr(A_IE, 32'd0, 1'b0);

    // Edge source 7, second pulse while in service.
    wr(A_PRIO + 4 * 7, 32'd1, 1'b0);
    wr(A_EDGE, 32'h80, 1'b0);
    wr(A_IE, 32'h80, 1'b0);
    irq_i[7] = 1'b1;
    cycles(1);
    irq_i[7] = 1'b0;
    cycles(2);
    rd_chk("e7_claim1", A_CPC, 32'd7, 1'b0);
    irq_i[7] = 1'b1;
    cycles(1);
    irq_i[7] = 1'b0;
    cycles(1);
    rd_chk("e7_ip_again", A_IP, 32'h80, 1'b0);
    wr(A_CPC, 32'd7, 1'b0);
    rd_chk("e7_claim2", A_CPC, 32'd7, 1'b0);
    wr(A_CPC, 32'd7, 1'b0);
    rd_chk("e7_ip_clear", A_IP, 32'd0, 1'b0);
    wr(A_EDGE, 32'd0, 1'b0);
    wr(A_IE, 32'd0, 1'b0);

    // Threshold boundary with source 4 at priority 3.
    wr(A_PRIO + 4 * 4, 32'd3, 1'b0);
    wr(A_IE, 32'h10, 1'b0);
    wr(A_THR, 32'd3, 1'b0);
    irq_i[4] = 1'b1;
    cycles(3);
    check("thr3_valid", 32'(core_ex_trap_valid_o), 32'd0);
    check("thr3_id", 32'(core_ex_trap_id_o), 32'd4);
    rd_chk("thr3_claim", A_CPC, 32'd4, 1'b0);
    wr(A_CPC, 32'd4, 1'b0);
    wr(A_THR, 32'd2, 1'b0);
    cycles(2);
    check("thr2_valid", 32'(core_ex_trap_valid_o), 32'd1);
    check("thr2_id", 32'(core_ex_trap_id_o), 32'd4);
    irq_i[4] = 1'b0;
    rd_chk("thr2_claim", A_CPC, 32'd4, 1'b0);
    wr(A_CPC, 32'd4, 1'b0);
    wr(A_IE, 32'd0, 1'b0);
    wr(A_THR, 32'd0, 1'b0);

    // Unmapped accesses and response back-pressure.
    wr(32'h4000, 32'hdead_beef, 1'b1);
    wr(A_IP, 32'hffff_ffff, 1'b0);
    rd_chk("ip_ro", A_IP, 32'd0, 1'b0);
    rd_chk("prio32_unmapped", 32'h80, 32'd0, 1'b1);
    rd_chk("cpc_out_of_range", A_CPC, 32'd0, 1'b0);
    wr(A_CPC, 32'd40, 1'b0);
    @(negedge clk);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = 32'h0;
    icb_rsp_ready = 1'b0;
    @(negedge clk);
    icb_cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("hold_rsp_valid", 32'(icb_rsp_valid), 32'd1);
      check("hold_rsp_err", 32'(icb_rsp_err), 32'd1);
      check("hold_rsp_rdata", icb_rsp_rdata, 32'd0);
      check("hold_cmd_ready", 32'(icb_cmd_ready), 32'd0);
      @(negedge clk);
    end
    icb_rsp_ready = 1'b1;
    cycles(1);
    check("hold_released", 32'(icb_rsp_valid), 32'd0);

    // Bus claim and core claim in the same cycle on source 2.
    wr(A_PRIO + 4 * 2, 32'd5, 1'b0);
    wr(A_IE, 32'h4, 1'b0);
    irq_i[2] = 1'b1;
    cycles(2);
    check("dual_id", 32'(core_ex_trap_id_o), 32'd2);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = 32'(A_CPC);
    core_ex_trap_ready_i = 1'b1;
    cycles(1);
    icb_cmd_valid = 1'b0;
    core_ex_trap_ready_i = 1'b0;
    check("dual_rsp_valid", 32'(icb_rsp_valid), 32'd1);
    check("dual_rdata", icb_rsp_rdata, 32'd2);
    rd_chk("dual_ip", A_IP, 32'd0, 1'b0);
    wr(A_CPC, 32'd2, 1'b0);
    rd_chk("dual_ip_reset", A_IP, 32'h4, 1'b0);
    irq_i[2] = 1'b0;
    rd_chk("dual_claim", A_CPC, 32'd2, 1'b0);
    wr(A_CPC, 32'd2, 1'b0);

    // Reset while a response is pending.
    @(negedge clk);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = 32'(A_IE);
    icb_rsp_ready = 1'b0;
    @(negedge clk);
    icb_cmd_valid = 1'b0;
    check("mid_rsp_pending", 32'(icb_rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(icb_cmd_ready), 32'd1);
    check("mid_rst_trap_valid", 32'(core_ex_trap_valid_o), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    icb_rsp_ready = 1'b1;
    rd_chk("post_rst_prio2", A_PRIO + 4 * 2, 32'd0, 1'b0);
    cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/plic_ng.md
PLIC_NG -- requirements
Module: plic_ng

Interface
REQ-001 Parameter NSRC, default 31: number of interrupt sources, IDs 1..NSRC, ID 0 reserved; legal range 1..31.
REQ-002 Parameter PRIO_W, default 3: priority and threshold width in bits; legal range 1..5.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 icb_cmd_valid/ready  in/out  1  ICB command handshake.
REQ-006 icb_cmd_addr  input  32  byte address; bits [27:0] are decoded.
REQ-007 icb_cmd_read  input  1  1 = read, 0 = write.
REQ-008 icb_cmd_wdata  input  32  write data; icb_cmd_wmask input 4, ignored (full-word access only).
REQ-009 icb_rsp_valid/ready  out/in  1  ICB response handshake.
REQ-010 icb_rsp_rdata  output  32  read data; icb_rsp_err output 1, unmapped-address flag.
REQ-011 irq_i  input  NSRC+1  source lines, synchronous to clk; bit 0 ignored.
REQ-012 core_ex_trap_valid_o  output  1  external interrupt request to hart context 0.
REQ-013 core_ex_trap_id_o  output  5  ID of the winning source.
REQ-014 core_ex_trap_ready_i  input  1  core claim strobe.

Function
REQ-015 Register map: PRIO[i] at 4*i; IP at 0x1000 (RO); IE at 0x2000; EDGE at 0x3000 (1 = rising-edge, 0 = level-high); THR at 0x200000; CLAIM/COMPLETE at 0x200004.
REQ-016 One transaction outstanding: cmd_ready = ~rsp_valid | rsp_ready; reads and writes both respond.
REQ-017 Response timing: rsp_valid rises the cycle after the command handshake and holds, with rdata/err stable, until rsp_ready.
REQ-018 Unmapped address, or PRIO[0]/PRIO[i>NSRC]: reads return 0, writes are ignored, err=1; reads of mapped bits above NSRC or PRIO_W return 0.
REQ-019 Writes to IP are ignored with err=0; all register writes take effect at the handshake edge.
REQ-020 Gateway, per source i, level mode: IP[i] is set while irq_i[i]=1 and in_service[i]=0.
REQ-021 Gateway, edge mode: IP[i] is set on a 0→1 change of irq_i[i], regardless of in_service; at most one edge is recorded.
REQ-022 Arbitration candidates: IP & IE & PRIO>0; highest PRIO wins, ties go to the lowest ID; best_id=0 when there is no candidate.
REQ-023 Outputs are registered, one cycle after the inputs: core_ex_trap_id_o = best_id, core_ex_trap_valid_o = (best_prio > THR).
REQ-024 Claim, by a bus read of CLAIM or by core_ex_trap_ready_i with the registered id: clears IP[id], sets in_service[id]; a bus claim returns id, or 0 if none.
REQ-025 Bus claim and core claim in the same cycle: the core claim is performed; the bus read returns the core id; a single claim results.
REQ-026 Claim and a new level/edge assertion in the same cycle for the same source: the claim wins and IP ends at 0; a new edge re-sets IP next cycle only if it occurs again.
REQ-027 Complete, by a bus write to CPC with id: clears in_service[id]; id=0, id>NSRC, or a source not in service is ignored with err=0.
REQ-028 Changing EDGE[i] clears IP[i] and the edge-history bit in the same cycle.

Reset
REQ-029 Reset clears PRIO, IE, EDGE, THR, IP, in_service and the edge-history bits to 0.
REQ-030 Reset drives rsp_valid=0, rsp_err=0, rsp_rdata=0, core_ex_trap_valid_o=0 and core_ex_trap_id_o=0; cmd_ready=1.
REQ-031 Reset mid-transaction drops any pending response without a handshake.

Structure
REQ-032 Register offsets and the NSRC/PRIO_W maxima live in the shared defines header as PLIC_* constants.
REQ-033 Per-source pending, in_service and edge logic lives in sub-module plic_gateway, instantiated NSRC times in a generate loop.
REQ-034 The arbiter is a linear compare chain inside plic_ng; no other sub-modules.

Verification
REQ-035 Level source 3, PRIO=2, IE set, THR=1, irq_i[3] held high: valid=1 and id=3 at +2 cycles; core claim drops valid; IP[3] stays 0 until complete(3), then re-sets.
REQ-036 Sources 5 and 9 both PRIO=4, both pending: id=5; after claiming 5, id=9 next cycle.
REQ-037 Edge source 7, two pulses, the second while in service: IP[7]=1 after the second pulse; a read of CLAIM returns 7 twice across two services.
REQ-038 THR=3, single source with PRIO=3: valid stays 0, yet a CLAIM read returns the ID; THR=2 gives valid=1.
REQ-039 Write to 0x4000, read of 0x0: rsp_err=1 and rdata=0; with rsp_ready held low for 3 cycles, rsp holds and cmd_ready=0.
REQ-040 Bus CLAIM read coinciding with core_ex_trap_ready_i: one claim is performed, the bus returns the same id, and in_service has exactly one bit set.
